// File: rtl/n64_pi_master.sv
// N64 parallel-interface initiator: address phases, hold, per-word strobes.
// Optional macro N64_PI_MASTER_ALIGN_CHECK_EN rejects odd-address requests.
module n64_pi_master #(
    parameter int ALE_CYCLES     = 4,
    parameter int HOLD_CYCLES    = 4,
    parameter int STROBE_CYCLES  = 8,
    parameter int RECOVER_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [7:0]  length,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic [15:0] wdata,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        n64_pi_aleh,
    output logic        n64_pi_alel,
    output logic        n64_pi_read,
    output logic        n64_pi_write,
    output logic [15:0] n64_pi_ad_out,
    output logic        n64_pi_ad_oe,
    input  logic [15:0] n64_pi_ad_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALEH,
        S_ALEL,
        S_HOLD,
        S_WAITD,
        S_STROBE,
        S_RECOVER
    } state_t;

    localparam logic [7:0] ALE_R = 8'(ALE_CYCLES - 1);
    localparam logic [7:0] HLD_R = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] STB_R = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] REC_R = 8'(RECOVER_CYCLES - 1);

    state_t      r_state;
    state_t      w_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_reload;
    logic [8:0]  r_words;
    logic [15:0] r_alo;
    logic        r_wr;
    logic        w_accept;
    logic        w_reject;
    logic        w_last;
    logic        w_take;
    logic        w_sdone;

    always_comb begin
        w_nxt    = r_state;
        w_accept = 1'b0;
        w_reject = 1'b0;
        w_last   = (r_cnt == 8'd0);
        w_reload = 8'd0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
`ifdef N64_PI_MASTER_ALIGN_CHECK_EN
                    if (address[0]) w_reject = 1'b1;
                    else            w_accept = 1'b1;
`else
                    w_accept = 1'b1;
`endif
                end
                if (w_accept) w_nxt = S_ALEH;
            end
            S_ALEH:   if (w_last) w_nxt = S_ALEL;
            S_ALEL:   if (w_last) w_nxt = S_HOLD;
            S_HOLD:   if (w_last) w_nxt = S_WAITD;
            S_WAITD:  if (!r_wr || wdata_valid) w_nxt = S_STROBE;
            S_STROBE: if (w_last) w_nxt = S_RECOVER;
            S_RECOVER: begin
                if (w_last) w_nxt = (r_words == 9'd0) ? S_IDLE : S_WAITD;
            end
            default:  w_nxt = S_IDLE;
        endcase
        case (w_nxt)
            S_ALEH, S_ALEL: w_reload = ALE_R;
            S_HOLD:         w_reload = HLD_R;
            S_STROBE:       w_reload = STB_R;
            S_RECOVER:      w_reload = REC_R;
            default:        w_reload = 8'd0;
        endcase
    end

    // Phase counter reloads on every state change, otherwise counts down to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_nxt;
            if (w_nxt != r_state) r_cnt <= w_reload;
            else if (!w_last)     r_cnt <= r_cnt - 8'd1;
        end
    end

    assign w_take  = (r_state == S_WAITD) && (w_nxt == S_STROBE);
    assign w_sdone = (r_state == S_STROBE) && (w_nxt == S_RECOVER);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr          <= 1'b0;
            r_alo         <= 16'd0;
            r_words       <= 9'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            wdata_ready   <= 1'b0;
            rdata         <= 16'd0;
            rdata_valid   <= 1'b0;
            n64_pi_aleh   <= 1'b0;
            n64_pi_alel   <= 1'b0;
            n64_pi_read   <= 1'b1;
            n64_pi_write  <= 1'b1;
            n64_pi_ad_out <= 16'd0;
            n64_pi_ad_oe  <= 1'b0;
        end else begin
            busy         <= (w_nxt != S_IDLE);
            done         <= (r_state == S_RECOVER) && (w_nxt == S_IDLE);
            error        <= w_reject;
            wdata_ready  <= w_take && r_wr;
            rdata_valid  <= w_sdone && !r_wr;
            n64_pi_aleh  <= (w_nxt == S_ALEH);
            n64_pi_alel  <= (w_nxt == S_ALEH) || (w_nxt == S_ALEL);
            n64_pi_read  <= !((w_nxt == S_STROBE) && !r_wr);
            n64_pi_write <= !((w_nxt == S_STROBE) && r_wr);
            case (w_nxt)
                S_IDLE:         n64_pi_ad_oe <= 1'b0;
                S_ALEH, S_ALEL: n64_pi_ad_oe <= 1'b1;
                default:        n64_pi_ad_oe <= r_wr;
            endcase
            if (w_accept) begin
                r_wr          <= write;
                r_alo         <= address[15:0] & 16'hFFFE;
                r_words       <= (length == 8'd0) ? 9'd256 : {1'b0, length};
                n64_pi_ad_out <= address[31:16];
            end
            if ((r_state == S_ALEH) && (w_nxt == S_ALEL)) n64_pi_ad_out <= r_alo;
            if (w_take && r_wr) n64_pi_ad_out <= wdata;
            if (w_sdone) r_words <= r_words - 9'd1;
            if (w_sdone && !r_wr) rdata <= n64_pi_ad_in;
        end
    end

endmodule

// File: tb/tb_n64_pi_master.sv
// Randomised scoreboard bench for n64_pi_master with a behavioural PI target.
module tb_n64_pi_master;

    localparam int ALE = 4;
    localparam int HLD = 4;
    localparam int STB = 8;
    localparam int REC = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        write = 1'b0;
    logic [31:0] address = 32'd0;
    logic [7:0]  length = 8'd0;
    logic [15:0] wdata = 16'd0;
    logic        wdata_valid = 1'b0;
    logic        busy, done, error, wdata_ready, rdata_valid;
    logic [15:0] rdata;
    logic        aleh, alel, rd_n, wr_n, ad_oe;
    logic [15:0] ad_out;
    logic [15:0] ad_in;

    n64_pi_master dut (
        .clk(clk), .reset(reset), .req(req), .write(write),
        .address(address), .length(length),
        .busy(busy), .done(done), .error(error),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid),
        .n64_pi_aleh(aleh), .n64_pi_alel(alel),
        .n64_pi_read(rd_n), .n64_pi_write(wr_n),
        .n64_pi_ad_out(ad_out), .n64_pi_ad_oe(ad_oe),
        .n64_pi_ad_in(ad_in)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: expected event missing or unexpected event", nm);
    endtask

    // Target memory contents as a pure function of byte address.
    function automatic logic [15:0] tgt(input logic [31:0] a);
        if (a == 32'h1000_0000) return 16'hBEEF;
        return a[16:1] ^ a[31:16] ^ 16'hA5C3;
    endfunction

    logic [31:0] q_addr[$];
    logic [15:0] q_rd[$];
    logic [15:0] q_wr[$];
    int          q_done[$];
    int          exp_err = 0;

    logic        p_rd = 1'b1, p_wr = 1'b1, p_alel = 1'b0;
    logic [15:0] hi = 16'd0, lo = 16'd0;
    logic [31:0] ptr = 32'd0;
    int          run_len = 0, wcnt = 0, n_strobe = 0, since_rise = 0;

    assign ad_in = tgt(ptr);

    always @(negedge clk) begin
        if (reset) begin
            p_rd = 1'b1; p_wr = 1'b1; p_alel = 1'b0;
            run_len = 0; wcnt = 0;
            q_addr.delete(); q_rd.delete(); q_wr.delete(); q_done.delete();
        end else begin
            since_rise++;
            if (aleh) hi = ad_out;
            else if (alel) lo = ad_out;
            if (p_alel && !alel) begin
                if (q_addr.size() > 0) chk("address", {hi, lo}, q_addr.pop_front());
                else fail("address_unexpected");
                ptr = {hi, lo};
                wcnt = 0;
            end
            if (!rd_n && !wr_n) fail("both_strobes_low");
            if ((!rd_n || !wr_n) && p_rd && p_wr) begin
                n_strobe++;
                wcnt++;
                run_len = 0;
                chk("ad_oe_in_strobe", {31'd0, ad_oe}, {31'd0, !wr_n});
                if (!wr_n) begin
                    if (q_wr.size() > 0) chk("write_word", {16'd0, ad_out}, {16'd0, q_wr.pop_front()});
                    else fail("write_unexpected");
                end
            end
            if (!rd_n || !wr_n) run_len++;
            if (rd_n && wr_n && (!p_rd || !p_wr)) begin
                chk("strobe_width", run_len, STB);
                ptr = ptr + 32'd2;
                since_rise = 0;
            end
            if (rdata_valid) begin
                chk("rvalid_on_rise", {31'd0, rd_n}, 32'd1);
                if (q_rd.size() > 0) chk("rdata", {16'd0, rdata}, {16'd0, q_rd.pop_front()});
                else fail("rdata_unexpected");
            end
            if (done) begin
                if (q_done.size() > 0) chk("word_count", wcnt, q_done.pop_front());
                else fail("done_unexpected");
                chk("done_gap", since_rise, REC);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
                chk("oe_at_done", {31'd0, ad_oe}, 32'd0);
            end
            if (error) begin
                if (exp_err > 0) exp_err--;
                else fail("error_unexpected");
            end
            p_rd = rd_n; p_wr = wr_n; p_alel = alel;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit wr, input logic [31:0] a, input logic [7:0] len);
        tick();
        req = 1'b1; write = wr; address = a; length = len;
        tick();
        req = 1'b0;
    endtask

    function automatic logic [31:0] eff_addr(input logic [31:0] a);
`ifdef N64_PI_MASTER_ALIGN_CHECK_EN
        return a;
`else
        return {a[31:1], 1'b0};
`endif
    endfunction

    task automatic run(input bit wr, input logic [31:0] a, input logic [7:0] len,
                       input int gapmax, input int gidx, input int glen,
                       input bit fixed, input bit lat);
        int n;
        logic [31:0] ea;
        logic [15:0] words[$];
        n = (len == 8'd0) ? 256 : int'(len);
        ea = eff_addr(a);
        q_addr.push_back(ea);
        q_done.push_back(n);
        for (int i = 0; i < n; i++) begin
            if (wr) begin
                logic [15:0] w;
                w = fixed ? 16'(16'h1111 * (i + 1)) : 16'($urandom);
                words.push_back(w);
                q_wr.push_back(w);
            end else begin
                q_rd.push_back(tgt(ea + 32'(2 * i)));
            end
        end
        issue(wr, a, len);
        fork
            begin
                if (wr) begin
                    for (int i = 0; i < n; i++) begin
                        int g;
                        bit got;
                        g = (i == gidx) ? glen :
                            (gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
                        if (g > 0) begin
                            wdata_valid = 1'b0;
                            for (int k = 0; k < g; k++) tick();
                            if (i == gidx) begin
                                chk("stall_strobe_high", {31'd0, wr_n}, 32'd1);
                                chk("stall_busy", {31'd0, busy}, 32'd1);
                            end
                        end
                        wdata = words[i];
                        wdata_valid = 1'b1;
                        got = 1'b0;
                        for (int k = 0; k < 2000; k++) begin
                            @(negedge clk);
                            if (wdata_ready) begin got = 1'b1; break; end
                        end
                        if (!got) begin fail("wdata_ready_timeout"); break; end
                    end
                    wdata_valid = 1'b0;
                end
            end
            begin
                if (lat) begin
                    int c;
                    c = 0;
                    for (int k = 0; k < 100; k++) begin
                        @(negedge clk);
                        c++;
                        if (!rd_n || !wr_n) break;
                    end
                    chk("latency", c, 2 * ALE + HLD + 2);
                end
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int k = 0; k < 6000; k++) begin
                    @(negedge clk);
                    if (done) begin seen = 1'b1; break; end
                end
                if (!seen) fail("done_timeout");
            end
        join
        tick();
    endtask

    initial begin
        repeat (3) tick();
        @(negedge clk);
        chk("rst_aleh", {31'd0, aleh}, 32'd0);
        chk("rst_alel", {31'd0, alel}, 32'd0);
        chk("rst_read", {31'd0, rd_n}, 32'd1);
        chk("rst_write", {31'd0, wr_n}, 32'd1);
        chk("rst_oe", {31'd0, ad_oe}, 32'd0);
        chk("rst_ad_out", {16'd0, ad_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_wready", {31'd0, wdata_ready}, 32'd0);
        chk("rst_rvalid", {31'd0, rdata_valid}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        run(1'b0, 32'h1000_0000, 8'd1, 0, -1, 0, 1'b0, 1'b1);
        run(1'b1, 32'h1000_0100, 8'd4, 0, -1, 0, 1'b1, 1'b1);
        run(1'b1, 32'h1000_0200, 8'd4, 0, 2, 20, 1'b0, 1'b1);

        // Back-to-back req after done must be taken; mid-burst req ignored.
        issue(1'b0, 32'h1000_0300, 8'd2);
        q_addr.push_back(32'h1000_0300);
        q_done.push_back(2);
        q_rd.push_back(tgt(32'h1000_0300));
        q_rd.push_back(tgt(32'h1000_0302));
        tick();
        req = 1'b1; address = 32'h2000_0000; length = 8'd9;
        tick();
        req = 1'b0;
        @(negedge clk);
        chk("req_while_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("idle_after_ignored", {31'd0, busy}, 32'd0);

        run(1'b0, 32'h1001_0000, 8'd0, 0, -1, 0, 1'b0, 1'b1);

        n_strobe = 0;
        q_addr.push_back(32'h1002_0000);
        q_done.push_back(16);
        for (int i = 0; i < 16; i++) q_rd.push_back(tgt(32'h1002_0000 + 32'(2 * i)));
        issue(1'b0, 32'h1002_0000, 8'd16);
        begin
            bit hit;
            hit = 1'b0;
            for (int k = 0; k < 500; k++) begin
                tick();
                if (n_strobe == 3) begin hit = 1'b1; break; end
            end
            if (!hit) fail("third_strobe_timeout");
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_read", {31'd0, rd_n}, 32'd1);
        chk("midrst_oe", {31'd0, ad_oe}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        run(1'b0, 32'h1003_0000, 8'd2, 0, -1, 0, 1'b0, 1'b1);

`ifdef N64_PI_MASTER_ALIGN_CHECK_EN
        exp_err++;
        issue(1'b0, 32'h1000_0001, 8'd1);
        @(negedge clk);
        chk("odd_error", {31'd0, error}, 32'd1);
        chk("odd_busy", {31'd0, busy}, 32'd0);
        chk("odd_aleh", {31'd0, aleh}, 32'd0);
        @(negedge clk);
        chk("odd_error_pulse", {31'd0, error}, 32'd0);
        chk("odd_oe", {31'd0, ad_oe}, 32'd0);
`else
        run(1'b0, 32'h1000_0001, 8'd1, 0, -1, 0, 1'b0, 1'b1);
        chk("odd_ad_low", {16'd0, lo}, 32'd0);
`endif

        for (int t = 0; t < 20; t++) begin
            logic [31:0] a;
            bit wr;
            a = $urandom;
`ifdef N64_PI_MASTER_ALIGN_CHECK_EN
            a[0] = 1'b0;
`endif
            wr = 1'($urandom_range(0, 1));
            run(wr, a, 8'($urandom_range(1, 6)), 3, -1, 0, 1'b0, 1'b0);
        end

        repeat (5) tick();
        chk("queues_drained",
            q_addr.size() + q_rd.size() + q_wr.size() + q_done.size(), 0);
        chk("errors_seen", exp_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
